// File: rtl/artau_multi_pulse_if.sv
// Bundles the mission-controller and radar front-end signals of artau_multi_pulse.
// The master side drives requests and echo; the slave side is the tracking unit.
interface artau_multi_pulse_if #(
  parameter int W    = 32,
  parameter int PI_W = 2
);
  logic            radar_echo;
  logic            scan_for_target;
  logic [W-1:0]    jet_speed;
  logic [W-1:0]    max_safe_distance;
  logic            radar_pulse_trigger;
  logic [W-1:0]    distance_to_target;
  logic            threat_detected;
  logic [1:0]      ARTAU_state;
  logic            measurement_valid;
  logic [PI_W-1:0] pulse_index;

  modport master (
    output radar_echo, scan_for_target, jet_speed, max_safe_distance,
    input  radar_pulse_trigger, distance_to_target, threat_detected,
           ARTAU_state, measurement_valid, pulse_index
  );

  modport slave (
    input  radar_echo, scan_for_target, jet_speed, max_safe_distance,
    output radar_pulse_trigger, distance_to_target, threat_detected,
           ARTAU_state, measurement_valid, pulse_index
  );
endinterface

// File: rtl/artau_multi_pulse.sv
// Multi-pulse radar ranging unit: times echoes in clocks, converts to range, flags closing threats.
// Optional macro ARTAU_RETRY_EN re-fires a pulse on listen timeout up to MAX_RETRIES times.
module artau_multi_pulse #(
  parameter int W               = 32,
  parameter int PULSE_CYCLES    = 7,
  parameter int LISTEN_CYCLES   = 40,
  parameter int HOLD_CYCLES     = 60,
  parameter int NUM_PULSES      = 2,
  parameter int RANGE_PER_CYCLE = 150,
  parameter int CLK_HZ          = 1000000,
  parameter int MAX_RETRIES     = 1
) (
  input logic                CLK,
  input logic                RST_N,
  artau_multi_pulse_if.slave bus
);
  localparam int PI_W = $clog2(NUM_PULSES + 1);
  localparam int EC_W = $clog2(PULSE_CYCLES + 1);
  localparam int LC_W = $clog2(LISTEN_CYCLES + 1);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam int RW   = W + 32;
  localparam logic [2*W-1:0] CLK_HZ_W = (2*W)'(CLK_HZ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    LISTEN = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              echo_q, echo_d;
  logic              trig_q, trig_d;
  logic              mv_q, mv_d;
  logic              threat_q, threat_d;
  logic              run_q, run_d;
  logic [W-1:0]      dist_q, dist_d;
  logic [W-1:0]      d_first_q, d_first_d;
  logic [W-1:0]      elapsed_q, elapsed_d;
  logic [PI_W-1:0]   pulse_index_q, pulse_index_d;
  logic [EC_W-1:0]   emit_cnt_q, emit_cnt_d;
  logic [LC_W-1:0]   listen_cnt_q, listen_cnt_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;

`ifdef ARTAU_RETRY_EN
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RC_W-1:0]   retry_cnt_q, retry_cnt_d;
`else
  localparam int unused_max_retries = MAX_RETRIES;
`endif

  logic              echo_edge;
  logic              start_meas;
  logic              go_idle;
  logic [RW-1:0]     range_full;
  logic [W-1:0]      range_val;
  logic [W-1:0]      elapsed_now;
  logic [2*W-1:0]    speed_prod;
  logic [W+1:0]      speed_term;
  logic signed [W+1:0] rel;

  // Range and closing-rate arithmetic for an echo arriving in the current cycle.
  always_comb begin
    echo_edge   = bus.radar_echo & ~echo_q;
    range_full  = RW'(listen_cnt_q) * RW'(RANGE_PER_CYCLE);
    range_val   = (|range_full[RW-1:W]) ? '1 : range_full[W-1:0];
    elapsed_now = elapsed_q + W'(1);
    speed_prod  = (2*W)'(bus.jet_speed) * (2*W)'(elapsed_now);
    speed_term  = (W+2)'(speed_prod / CLK_HZ_W);
    rel         = $signed({2'b00, range_val}) + $signed(speed_term)
                - $signed({2'b00, d_first_q});
  end

  always_comb begin
    state_d       = state_q;
    echo_d        = bus.radar_echo;
    trig_d        = trig_q;
    mv_d          = 1'b0;
    threat_d      = threat_q;
    run_d         = run_q;
    dist_d        = dist_q;
    d_first_d     = d_first_q;
    elapsed_d     = elapsed_q;
    pulse_index_d = pulse_index_q;
    emit_cnt_d    = emit_cnt_q;
    listen_cnt_d  = listen_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    start_meas    = 1'b0;
    go_idle       = 1'b0;
`ifdef ARTAU_RETRY_EN
    retry_cnt_d   = retry_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.scan_for_target) start_meas = 1'b1;
      end
      EMIT: begin
        if (run_q) elapsed_d = elapsed_now;
        if (emit_cnt_q == EC_W'(PULSE_CYCLES)) begin
          state_d      = LISTEN;
          trig_d       = 1'b0;
          listen_cnt_d = LC_W'(1);
        end else begin
          emit_cnt_d = emit_cnt_q + EC_W'(1);
        end
      end
      LISTEN: begin
        elapsed_d = elapsed_now;
        run_d     = 1'b1;
        if (echo_edge) begin
          dist_d = range_val;
          if (pulse_index_q == PI_W'(1)) d_first_d = range_val;
          if (pulse_index_q < PI_W'(NUM_PULSES)) begin
            state_d       = EMIT;
            trig_d        = 1'b1;
            emit_cnt_d    = EC_W'(1);
            pulse_index_d = pulse_index_q + PI_W'(1);
`ifdef ARTAU_RETRY_EN
            retry_cnt_d   = '0;
`endif
          end else begin
            threat_d   = (bus.max_safe_distance > range_val) && rel[W+1];
            mv_d       = 1'b1;
            state_d    = HOLD;
            hold_cnt_d = HC_W'(1);
          end
        end else if (listen_cnt_q == LC_W'(LISTEN_CYCLES)) begin
`ifdef ARTAU_RETRY_EN
          if (retry_cnt_q < RC_W'(MAX_RETRIES)) begin
            state_d     = EMIT;
            trig_d      = 1'b1;
            emit_cnt_d  = EC_W'(1);
            retry_cnt_d = retry_cnt_q + RC_W'(1);
          end else begin
            go_idle = 1'b1;
          end
`else
          go_idle = 1'b1;
`endif
        end else begin
          listen_cnt_d = listen_cnt_q + LC_W'(1);
        end
      end
      HOLD: begin
        if (bus.scan_for_target) start_meas = 1'b1;
        else if (hold_cnt_q == HC_W'(HOLD_CYCLES)) go_idle = 1'b1;
        else hold_cnt_d = hold_cnt_q + HC_W'(1);
      end
      default: go_idle = 1'b1;
    endcase

    // A restart from HOLD keeps the previous distance and threat visible.
    if (start_meas) begin
      state_d       = EMIT;
      trig_d        = 1'b1;
      emit_cnt_d    = EC_W'(1);
      pulse_index_d = PI_W'(1);
      elapsed_d     = '0;
      run_d         = 1'b0;
`ifdef ARTAU_RETRY_EN
      retry_cnt_d   = '0;
`endif
    end
    if (go_idle) begin
      state_d       = IDLE;
      trig_d        = 1'b0;
      dist_d        = '0;
      threat_d      = 1'b0;
      pulse_index_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      echo_q        <= 1'b0;
      trig_q        <= 1'b0;
      mv_q          <= 1'b0;
      threat_q      <= 1'b0;
      run_q         <= 1'b0;
      dist_q        <= '0;
      d_first_q     <= '0;
      elapsed_q     <= '0;
      pulse_index_q <= '0;
      emit_cnt_q    <= '0;
      listen_cnt_q  <= '0;
      hold_cnt_q    <= '0;
`ifdef ARTAU_RETRY_EN
      retry_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      echo_q        <= echo_d;
      trig_q        <= trig_d;
      mv_q          <= mv_d;
      threat_q      <= threat_d;
      run_q         <= run_d;
      dist_q        <= dist_d;
      d_first_q     <= d_first_d;
      elapsed_q     <= elapsed_d;
      pulse_index_q <= pulse_index_d;
      emit_cnt_q    <= emit_cnt_d;
      listen_cnt_q  <= listen_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
`ifdef ARTAU_RETRY_EN
      retry_cnt_q   <= retry_cnt_d;
`endif
    end
  end

  assign bus.radar_pulse_trigger = trig_q;
  assign bus.distance_to_target  = dist_q;
  assign bus.threat_detected     = threat_q;
  assign bus.ARTAU_state         = state_q;
  assign bus.measurement_valid   = mv_q;
  assign bus.pulse_index         = pulse_index_q;
endmodule

// File: tb/tb_artau_multi_pulse.sv
// Directed bench for artau_multi_pulse: inputs driven and outputs checked on the falling edge.
// Expected ranges are listen_cnt * 150 m; the threat cases use elapsed = 20 + 7 + 10 = 37 cycles.
module tb_artau_multi_pulse;
  localparam int W    = 32;
  localparam int NP   = 2;
  localparam int PI_W = $clog2(NP + 1);

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  artau_multi_pulse_if #(.W(W), .PI_W(PI_W)) bus ();

  artau_multi_pulse #(.W(W), .NUM_PULSES(NP)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic startScan();
    bus.scan_for_target = 1'b1;
    cyc(1);
    bus.scan_for_target = 1'b0;
  endtask

  // Called just after EMIT entry; returns just after the echo edge at listen_cnt k.
  task automatic applyStimulus(input int k);
    cyc(7);
    cyc(k - 1);
    bus.radar_echo = 1'b1;
    cyc(1);
    bus.radar_echo = 1'b0;
  endtask

  initial begin
    bus.radar_echo        = 1'b0;
    bus.scan_for_target   = 1'b0;
    bus.jet_speed         = '0;
    bus.max_safe_distance = 32'd5000;

    cyc(2);
    checkOutput("rst_state",  bus.ARTAU_state, 0);
    checkOutput("rst_trig",   bus.radar_pulse_trigger, 0);
    checkOutput("rst_dist",   bus.distance_to_target, 0);
    checkOutput("rst_threat", bus.threat_detected, 0);
    checkOutput("rst_mv",     bus.measurement_valid, 0);
    checkOutput("rst_pidx",   bus.pulse_index, 0);
    RST_N = 1'b1;
    cyc(1);

    // Echo at 10 on both pulses, stationary jet
    startScan();
    checkOutput("a_emit_state", bus.ARTAU_state, 1);
    checkOutput("a_emit_trig",  bus.radar_pulse_trigger, 1);
    checkOutput("a_emit_pidx",  bus.pulse_index, 1);
    cyc(6);
    checkOutput("a_trig_last",  bus.radar_pulse_trigger, 1);
    cyc(1);
    checkOutput("a_trig_fall",  bus.radar_pulse_trigger, 0);
    checkOutput("a_listen",     bus.ARTAU_state, 2);
    cyc(9);
    bus.radar_echo = 1'b1;
    cyc(1);
    bus.radar_echo = 1'b0;
    checkOutput("a_p1_dist",  bus.distance_to_target, 1500);
    checkOutput("a_p1_state", bus.ARTAU_state, 1);
    checkOutput("a_p1_trig",  bus.radar_pulse_trigger, 1);
    checkOutput("a_p1_pidx",  bus.pulse_index, 2);
    applyStimulus(10);
    checkOutput("a_p2_dist",   bus.distance_to_target, 1500);
    checkOutput("a_p2_threat", bus.threat_detected, 0);
    checkOutput("a_p2_mv",     bus.measurement_valid, 1);
    checkOutput("a_p2_state",  bus.ARTAU_state, 3);
    cyc(1);
    checkOutput("a_mv_strobe", bus.measurement_valid, 0);
    cyc(58);
    checkOutput("a_hold59_state", bus.ARTAU_state, 3);
    checkOutput("a_hold59_dist",  bus.distance_to_target, 1500);
    cyc(1);
    checkOutput("a_hold60_state", bus.ARTAU_state, 0);
    checkOutput("a_hold60_dist",  bus.distance_to_target, 0);

    // Echo 20 then 10, jet 300 m/s, threshold equal to d_last
    bus.jet_speed         = 32'd300;
    bus.max_safe_distance = 32'd1500;
    startScan();
    applyStimulus(20);
    checkOutput("b2_p1_dist", bus.distance_to_target, 3000);
    applyStimulus(10);
    checkOutput("b2_dist",   bus.distance_to_target, 1500);
    checkOutput("b2_threat", bus.threat_detected, 0);
    checkOutput("b2_mv",     bus.measurement_valid, 1);
    cyc(29);
    bus.scan_for_target = 1'b1;
    cyc(1);
    bus.scan_for_target = 1'b0;
    checkOutput("hold30_state", bus.ARTAU_state, 1);
    checkOutput("hold30_dist",  bus.distance_to_target, 1500);
    checkOutput("hold30_pidx",  bus.pulse_index, 1);

    // Same echoes, threshold 5000: rel = -1500
    bus.max_safe_distance = 32'd5000;
    applyStimulus(20);
    applyStimulus(10);
    checkOutput("b1_threat", bus.threat_detected, 1);
    checkOutput("b1_mv",     bus.measurement_valid, 1);

    // Speed term 1500 exactly: rel = 0
    bus.jet_speed = 32'd40540541;
    startScan();
    applyStimulus(20);
    applyStimulus(10);
    checkOutput("spd_rel0_threat", bus.threat_detected, 0);

    // Speed term truncates to 1499: rel = -1
    bus.jet_speed = 32'd40540540;
    startScan();
    applyStimulus(20);
    applyStimulus(10);
    checkOutput("spd_relm1_threat", bus.threat_detected, 1);
    bus.jet_speed = '0;

    // No echo after pulse 1
    startScan();
    checkOutput("to_threat_held", bus.threat_detected, 1);
    cyc(7);
    cyc(39);
    checkOutput("to_cnt40_state", bus.ARTAU_state, 2);
    cyc(1);
`ifdef ARTAU_RETRY_EN
    checkOutput("retry_state", bus.ARTAU_state, 1);
    checkOutput("retry_trig",  bus.radar_pulse_trigger, 1);
    checkOutput("retry_pidx",  bus.pulse_index, 1);
    cyc(6);
    checkOutput("retry_trig7", bus.radar_pulse_trigger, 1);
    cyc(1);
    checkOutput("retry_listen", bus.ARTAU_state, 2);
    cyc(40);
`endif
    checkOutput("to_state",  bus.ARTAU_state, 0);
    checkOutput("to_dist",   bus.distance_to_target, 0);
    checkOutput("to_threat", bus.threat_detected, 0);
    checkOutput("to_trig",   bus.radar_pulse_trigger, 0);

    // Reset at listen cycle 15 of pulse 2
    startScan();
    applyStimulus(10);
    checkOutput("rs_p1_dist", bus.distance_to_target, 1500);
    cyc(7);
    cyc(14);
    RST_N = 1'b0;
    cyc(1);
    checkOutput("rs_state", bus.ARTAU_state, 0);
    checkOutput("rs_dist",  bus.distance_to_target, 0);
    checkOutput("rs_pidx",  bus.pulse_index, 0);
    checkOutput("rs_trig",  bus.radar_pulse_trigger, 0);
    RST_N = 1'b1;
    bus.radar_echo = 1'b1;
    cyc(2);
    checkOutput("rs_late_echo_state", bus.ARTAU_state, 0);
    checkOutput("rs_late_echo_dist",  bus.distance_to_target, 0);
    bus.radar_echo = 1'b0;
    cyc(1);

    // Echo high during EMIT and held across the next pulse
    startScan();
    bus.radar_echo = 1'b1;
    cyc(7);
    checkOutput("lvl_emit_ignored", bus.ARTAU_state, 2);
    cyc(2);
    bus.radar_echo = 1'b0;
    cyc(1);
    bus.radar_echo = 1'b1;
    cyc(1);
    checkOutput("lvl_p1_dist",  bus.distance_to_target, 600);
    checkOutput("lvl_p1_state", bus.ARTAU_state, 1);
    cyc(7);
    cyc(9);
    checkOutput("lvl_held_state", bus.ARTAU_state, 2);
    checkOutput("lvl_held_dist",  bus.distance_to_target, 600);
    bus.radar_echo = 1'b0;
    cyc(30);
    bus.radar_echo = 1'b1;
    cyc(1);
    bus.radar_echo = 1'b0;
    checkOutput("edge40_dist",   bus.distance_to_target, 6000);
    checkOutput("edge40_state",  bus.ARTAU_state, 3);
    checkOutput("edge40_mv",     bus.measurement_valid, 1);
    checkOutput("edge40_threat", bus.threat_detected, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/artau_multi_pulse.md
# artau_multi_pulse

Parametrised successor to the single-shot airborne radar tracking unit (ARTAU). It emits a configurable train of radar pulses and times each echo in clock cycles, not simulation time. It converts each delay to range and flags a threat when the target is inside the safe distance and closing faster than the jet's own motion explains. It sits between the mission controller (scan request, jet speed, safety threshold) and the radar front end (pulse trigger, echo).

## Interface
Parameters:
- W, 32, width of speed, distance and threshold buses
- PULSE_CYCLES, 7, high time of each radar pulse in clocks (≥1)
- LISTEN_CYCLES, 40, echo window per pulse in clocks (≥1)
- HOLD_CYCLES, 60, result hold time in clocks (≥1)
- NUM_PULSES, 2, pulses per measurement (≥2)
- RANGE_PER_CYCLE, 150, metres per cycle of round-trip delay (c/2 × clock period)
- CLK_HZ, 1000000, clock frequency used to convert the speed term
- MAX_RETRIES, 1, retries per pulse on timeout (used only with ARTAU_RETRY_EN)

Ports:
- CLK  in  1  system clock; all logic on posedge
- RST_N  in  1  reset, synchronous, active-low
- radar_echo  in  1  echo from front end, synchronous to CLK
- scan_for_target  in  1  level request to start a measurement
- jet_speed  in  W  own speed, m/s, unsigned
- max_safe_distance  in  W  threat range threshold, m
- radar_pulse_trigger  out  1  pulse to transmitter
- distance_to_target  out  W  latest measured range, m
- threat_detected  out  1  threat flag
- ARTAU_state  out  2  0 IDLE, 1 EMIT, 2 LISTEN, 3 HOLD
- measurement_valid  out  1  one-cycle strobe when a full measurement completes
- pulse_index  out  $clog2(NUM_PULSES+1)  pulses emitted in current measurement

## Operation
- Reset (RST_N low at posedge): ARTAU_state=IDLE. All outputs are 0. All counters and stored distances are cleared. Reset aborts any in-flight measurement.
- Echo edge: echo_q holds radar_echo from the previous cycle; edge = radar_echo & ~echo_q. Edges outside LISTEN are ignored.
- IDLE: scan_for_target=1 → EMIT. pulse_index is cleared and the elapsed counter is reset.
- EMIT:
  - radar_pulse_trigger=1 for exactly PULSE_CYCLES cycles.
  - pulse_index increments on entry.
  - On the last cycle → LISTEN.
- LISTEN:
  - Trigger is 0. listen_cnt counts 1..LISTEN_CYCLES; the first LISTEN cycle is 1.
  - An edge with listen_cnt ≤ LISTEN_CYCLES gives range = listen_cnt × RANGE_PER_CYCLE, saturated to 2^W−1. distance_to_target is updated on that edge.
  - If pulse 1: store d_first.
  - If pulse_index < NUM_PULSES: → EMIT.
  - Otherwise:
    - Store d_last.
    - rel = d_last + (jet_speed × elapsed) / CLK_HZ − d_first. The product is 2W bits; rel is signed W+2 bits; division truncates.
    - threat_detected = (max_safe_distance > d_last) && (rel < 0).
    - measurement_valid=1 for one cycle, then → HOLD.
  - No edge by listen_cnt = LISTEN_CYCLES: → IDLE; distance_to_target=0, threat_detected=0.
- elapsed: counts every cycle from the first LISTEN cycle of pulse 1 up to and including the final echo cycle.
- HOLD:
  - Outputs are held. hold_cnt counts 1..HOLD_CYCLES.
  - scan_for_target=1 on any HOLD cycle → EMIT of a new measurement. distance and threat are held until the new result or a timeout.
  - hold_cnt reaches HOLD_CYCLES with scan low → IDLE; distance_to_target=0, threat_detected=0.
- scan_for_target dropping mid-measurement does not abort it.

## Timing
- Scan sampled high in IDLE at edge N: ARTAU_state=EMIT and trigger=1 from edge N.
- The trigger falls at edge N+PULSE_CYCLES, which is also LISTEN entry.
- Echo sampled at edge E: distance, state transition and (on the final pulse) threat and measurement_valid all update at edge E. There is zero extra latency.
- Between pulses, the next EMIT starts at edge E, so the trigger rises in the same cycle.
- Echo exactly on listen_cnt = LISTEN_CYCLES is accepted; the echo takes priority over the timeout.
- Reset has priority over every other event on the same edge.

## Configuration
- ARTAU_RETRY_EN defined:
  - A LISTEN timeout re-enters EMIT for the same pulse, without incrementing pulse_index, up to MAX_RETRIES times per pulse.
  - elapsed keeps counting through retries.
  - Retries are exhausted → IDLE with outputs cleared.
- ARTAU_RETRY_EN undefined: a timeout always goes to IDLE. The retry counter is not synthesised.

## Test plan
Defaults unless stated.
- Echo at listen_cnt 10 on both pulses, jet_speed 0, max_safe 5000 → distance 1500 after each echo; rel=0 → threat 0; measurement_valid pulses once.
- Echo at listen_cnt 20 then 10, jet_speed 300, max_safe 5000 → d_first=3000, d_last=1500, elapsed=37, speed term 0, rel=−1500 → threat 1. The same run with max_safe 1500 → threat 0.
- No echo after pulse 1 → at listen_cnt 40 → IDLE, distance 0, threat 0, trigger 0. With ARTAU_RETRY_EN: the trigger re-fires for 7 cycles with pulse_index still 1.
- HOLD:
  - scan low → IDLE and outputs clear exactly 60 cycles after HOLD entry.
  - scan high on hold cycle 30 → EMIT the next cycle, with the old distance still shown.
- RST_N low at listen cycle 15 → at that edge all outputs 0 and state IDLE. A later echo is ignored.
- Echo held high across two pulses, or present during EMIT → only a fresh rising edge inside LISTEN is counted.
